mem_arbiter: RTL and testbench

Two-master, one-slave memory arbiter between the core and its single memory port. It sits directly downstream of the core's instruction-fetch unit and load/store stage, serializes their requests onto one SRAM-style slave, and routes each response back to the master that issued it. There is one outstanding transaction at a time, and a registered grant decision is made in an idle cycle.

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (m0 = IFU, m1 = LSU) to one-slave memory arbiter.
// One outstanding transaction; the grant is registered in an IDLE cycle, then the
// request and response paths are muxed combinationally for the granted master.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-breaking. When it is
// undefined, the LSU (m1) wins every tie.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  // m0: instruction fetch unit
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic              m0_req_wen,
  input  logic [DATA_W-1:0] m0_req_wdata,
  input  logic [MASK_W-1:0] m0_req_wmask,
  output logic              m0_resp_valid,
  input  logic              m0_resp_ready,
  output logic [DATA_W-1:0] m0_resp_rdata,
  output logic              m0_resp_err,
  // m1: load/store unit
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic              m1_req_wen,
  input  logic [DATA_W-1:0] m1_req_wdata,
  input  logic [MASK_W-1:0] m1_req_wmask,
  output logic              m1_resp_valid,
  input  logic              m1_resp_ready,
  output logic [DATA_W-1:0] m1_resp_rdata,
  output logic              m1_resp_err,
  // slave
  output logic              s_req_valid,
  input  logic              s_req_ready,
  output logic [ADDR_W-1:0] s_req_addr,
  output logic              s_req_wen,
  output logic [DATA_W-1:0] s_req_wdata,
  output logic [MASK_W-1:0] s_req_wmask,
  input  logic              s_resp_valid,
  output logic              s_resp_ready,
  input  logic [DATA_W-1:0] s_resp_rdata,
  input  logic              s_resp_err
);

  typedef enum logic [2:0] {StIdle, StReq0, StReq1, StResp0, StResp1} state_e;

  state_e state_q, state_d;
  // 1'b1 = m1 was the most recent grant
  logic   last_grant_q, last_grant_d;
  logic   pick_m1;

  // Winner selection for the IDLE cycle
  always_comb begin
    pick_m1 = m1_req_valid;
`ifdef MEM_ARB_RR_EN
    if (m0_req_valid && m1_req_valid) begin
      pick_m1 = ~last_grant_q;
    end
`endif
  end

  // Next-state logic and grant bookkeeping
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req_valid || m1_req_valid) begin
          state_d      = pick_m1 ? StReq1 : StReq0;
          last_grant_d = pick_m1;
        end
      end
      StReq0:  if (s_req_ready) state_d = StResp0;
      StReq1:  if (s_req_ready) state_d = StResp1;
      StResp0: if (s_resp_valid && m0_resp_ready) state_d = StIdle;
      StResp1: if (s_resp_valid && m1_resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request/response muxing for the granted master; everything idles at 0
  always_comb begin
    s_req_valid   = 1'b0;
    s_req_addr    = '0;
    s_req_wen     = 1'b0;
    s_req_wdata   = '0;
    s_req_wmask   = '0;
    s_resp_ready  = 1'b0;
    m0_req_ready  = 1'b0;
    m0_resp_valid = 1'b0;
    m0_resp_rdata = '0;
    m0_resp_err   = 1'b0;
    m1_req_ready  = 1'b0;
    m1_resp_valid = 1'b0;
    m1_resp_rdata = '0;
    m1_resp_err   = 1'b0;
    unique case (state_q)
      StReq0: begin
        s_req_valid  = 1'b1;
        s_req_addr   = m0_req_addr;
        s_req_wen    = m0_req_wen;
        s_req_wdata  = m0_req_wdata;
        s_req_wmask  = m0_req_wmask;
        m0_req_ready = s_req_ready;
      end
      StReq1: begin
        s_req_valid  = 1'b1;
        s_req_addr   = m1_req_addr;
        s_req_wen    = m1_req_wen;
        s_req_wdata  = m1_req_wdata;
        s_req_wmask  = m1_req_wmask;
        m1_req_ready = s_req_ready;
      end
      StResp0: begin
        m0_resp_valid = s_resp_valid;
        m0_resp_rdata = s_resp_rdata;
        m0_resp_err   = s_resp_err;
        s_resp_ready  = m0_resp_ready;
      end
      StResp1: begin
        m1_resp_valid = s_resp_valid;
        m1_resp_rdata = s_resp_rdata;
        m1_resp_err   = s_resp_err;
        s_resp_ready  = m1_resp_ready;
      end
      default: ;
    endcase
  end

  // State register; reset abandons any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifndef SYNTHESIS
  // A granted master must hold req_valid until its request is accepted
  always @(posedge clk) begin
    if (!rst && state_q == StReq0) begin
      assert (m0_req_valid) else $error("m0 dropped req_valid before acceptance");
    end
    if (!rst && state_q == StReq1) begin
      assert (m1_req_valid) else $error("m1 dropped req_valid before acceptance");
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected slave requests and
// master responses into queues; monitors pop and compare on each handshake.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid, m0_req_ready, m0_req_wen, m0_resp_valid, m0_resp_ready, m0_resp_err;
  logic [31:0] m0_req_addr, m0_req_wdata, m0_resp_rdata;
  logic [7:0]  m0_req_wmask;
  logic        m1_req_valid, m1_req_ready, m1_req_wen, m1_resp_valid, m1_resp_ready, m1_resp_err;
  logic [31:0] m1_req_addr, m1_req_wdata, m1_resp_rdata;
  logic [7:0]  m1_req_wmask;
  logic        s_req_valid, s_req_ready, s_req_wen, s_resp_valid, s_resp_ready, s_resp_err;
  logic [31:0] s_req_addr, s_req_wdata, s_resp_rdata;
  logic [7:0]  s_req_wmask;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
    .m0_req_wen(m0_req_wen), .m0_req_wdata(m0_req_wdata), .m0_req_wmask(m0_req_wmask),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
    .m0_resp_rdata(m0_resp_rdata), .m0_resp_err(m0_resp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
    .m1_req_wen(m1_req_wen), .m1_req_wdata(m1_req_wdata), .m1_req_wmask(m1_req_wmask),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
    .m1_resp_rdata(m1_resp_rdata), .m1_resp_err(m1_resp_err),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
    .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
    .s_resp_rdata(s_resp_rdata), .s_resp_err(s_resp_err)
  );

  typedef struct {
    logic        m;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    logic [31:0] rdata;
    logic        err;
  } sreq_t;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  sreq_t exp_sreq[$];
  resp_t exp_r0[$];
  resp_t exp_r1[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Slave sees the request in grant order, then returns (rdata, err) to master m
  task automatic expect_txn(input logic m, input logic [31:0] addr, input logic wen,
                            input logic [31:0] wdata, input logic [7:0] wmask,
                            input logic [31:0] rdata, input logic err);
    sreq_t s;
    resp_t r;
    s = '{m: m, addr: addr, wen: wen, wdata: wdata, wmask: wmask, rdata: rdata, err: err};
    r = '{rdata: rdata, err: err};
    exp_sreq.push_back(s);
    if (m) exp_r1.push_back(r);
    else   exp_r0.push_back(r);
  endtask

  // Present a request on m0, hold until accepted; lat = negedges until accepted
  task automatic send0(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                       input logic [7:0] wmask, output int lat);
    bit done = 0;
    m0_req_addr = addr; m0_req_wen = wen; m0_req_wdata = wdata; m0_req_wmask = wmask;
    m0_req_valid = 1'b1;
    lat = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (m0_req_ready) done = 1;
    end
    if (!done) fail_now("m0 accept timeout");
    @(posedge clk); #1;
    m0_req_valid = 1'b0;
  endtask

  task automatic send1(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                       input logic [7:0] wmask, output int lat);
    bit done = 0;
    m1_req_addr = addr; m1_req_wen = wen; m1_req_wdata = wdata; m1_req_wmask = wmask;
    m1_req_valid = 1'b1;
    lat = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (m1_req_ready) done = 1;
    end
    if (!done) fail_now("m1 accept timeout");
    @(posedge clk); #1;
    m1_req_valid = 1'b0;
  endtask

  // Wait until every expected item has been seen, then realign to posedge+1
  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (exp_sreq.size() == 0 && exp_r0.size() == 0 && exp_r1.size() == 0) done = 1;
    end
    if (!done) fail_now("drain timeout");
    @(posedge clk); #1;
  endtask

  // Slave model + slave-side monitor: respond the cycle after request acceptance
  initial begin
    bit          hs, rhs;
    logic [31:0] nx_rdata;
    logic        nx_err;
    sreq_t       e;
    s_resp_valid = 1'b0;
    s_resp_rdata = '0;
    s_resp_err   = 1'b0;
    nx_rdata     = '0;
    nx_err       = 1'b0;
    forever begin
      @(negedge clk);
      hs  = s_req_valid && s_req_ready && !rst;
      rhs = s_resp_valid && s_resp_ready;
      if (hs) begin
        if (exp_sreq.size() == 0) begin
          fail_now("unexpected slave request");
        end else begin
          e = exp_sreq.pop_front();
          chk("sreq grant", {m1_req_ready, m0_req_ready}, e.m ? 2'b10 : 2'b01);
          chk("sreq addr",  s_req_addr,  e.addr);
          chk("sreq wen",   s_req_wen,   e.wen);
          chk("sreq wdata", s_req_wdata, e.wdata);
          chk("sreq wmask", s_req_wmask, e.wmask);
          nx_rdata = e.rdata;
          nx_err   = e.err;
        end
      end
      @(posedge clk); #1;
      if (rst || rhs) s_resp_valid = 1'b0;
      if (hs && !rst) begin
        s_resp_valid = 1'b1;
        s_resp_rdata = nx_rdata;
        s_resp_err   = nx_err;
      end
    end
  end

  // Master-side response monitor
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (m0_resp_valid && m0_resp_ready) begin
        chk("m1 quiet during m0 resp", m1_resp_valid, 1'b0);
        if (exp_r0.size() == 0) fail_now("unexpected m0 response");
        else begin
          r = exp_r0.pop_front();
          chk("m0 rdata", m0_resp_rdata, r.rdata);
          chk("m0 err",   m0_resp_err,   r.err);
        end
      end
      if (m1_resp_valid && m1_resp_ready) begin
        chk("m0 quiet during m1 resp", m0_resp_valid, 1'b0);
        if (exp_r1.size() == 0) fail_now("unexpected m1 response");
        else begin
          r = exp_r1.pop_front();
          chk("m1 rdata", m1_resp_rdata, r.rdata);
          chk("m1 err",   m1_resp_err,   r.err);
        end
      end
    end
  end

  // Global watchdog
  initial begin
    #200000;
    fail_now("global timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int lat0, lat1, cyc;
    bit seen;
    // ---- Reset with both masters requesting ----
    rst = 1'b1;
    s_req_ready = 1'b1;
    m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
    m0_req_addr = 32'h100; m0_req_wen = 1'b0; m0_req_wdata = '0; m0_req_wmask = '0;
    m1_req_addr = 32'h104; m1_req_wen = 1'b0; m1_req_wdata = '0; m1_req_wmask = '0;
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst s_req_valid", s_req_valid, 1'b0);
    chk("rst s_resp_ready", s_resp_ready, 1'b0);
    chk("rst m_req_ready", {m1_req_ready, m0_req_ready}, 2'b00);
    chk("rst m_resp_valid", {m1_resp_valid, m0_resp_valid}, 2'b00);
    chk("rst s_req_addr", s_req_addr, 32'h0);
    chk("rst m_rdata", {m1_resp_rdata, m0_resp_rdata}, 64'h0);
`ifdef MEM_ARB_RR_EN
    expect_txn(1'b0, 32'h100, 1'b0, 32'h0, 8'h0, 32'h11, 1'b0);
    expect_txn(1'b1, 32'h104, 1'b0, 32'h0, 8'h0, 32'h22, 1'b0);
`else
    expect_txn(1'b1, 32'h104, 1'b0, 32'h0, 8'h0, 32'h22, 1'b0);
    expect_txn(1'b0, 32'h100, 1'b0, 32'h0, 8'h0, 32'h11, 1'b0);
`endif
    #1 rst = 1'b0;
    fork
      send0(32'h100, 1'b0, 32'h0, 8'h0, lat0);
      send1(32'h104, 1'b0, 32'h0, 8'h0, lat1);
      begin
        @(negedge clk);
        chk("s_req_valid one cycle after reset", s_req_valid, 1'b1);
      end
    join
    drain();

    // ---- Single IFU read ----
    expect_txn(1'b0, 32'h8000_0000, 1'b0, 32'h0, 8'h0, 32'h0000_0413, 1'b0);
    fork
      send0(32'h8000_0000, 1'b0, 32'h0, 8'h0, lat0);
      begin
        cyc = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          cyc++;
          if (m0_resp_valid && m0_resp_ready) seen = 1;
        end
        @(negedge clk);
        cyc++;
        chk("ifu cycles to idle", cyc, 4);
        chk("ifu back to idle", {s_req_valid, m0_resp_valid, m1_resp_valid}, 3'b000);
      end
    join
    chk("ifu grant latency", lat0, 2);
    drain();

    // ---- Simultaneous requests ----
`ifdef MEM_ARB_RR_EN
    expect_txn(1'b0, 32'h8000_0004, 1'b0, 32'h0, 8'h0, 32'h0000_0093, 1'b0);
    expect_txn(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F, 32'h0, 1'b0);
`else
    expect_txn(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F, 32'h0, 1'b0);
    expect_txn(1'b0, 32'h8000_0004, 1'b0, 32'h0, 8'h0, 32'h0000_0093, 1'b0);
`endif
    fork
      send0(32'h8000_0004, 1'b0, 32'h0, 8'h0, lat0);
      send1(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F, lat1);
    join
`ifdef MEM_ARB_RR_EN
    chk("tie winner latency", lat0, 2);
    chk("tie loser latency", lat1, 5);
`else
    chk("tie winner latency", lat1, 2);
    chk("tie loser latency", lat0, 5);
`endif
    drain();

    // ---- Back-to-back ties, both masters re-requesting ----
`ifdef MEM_ARB_RR_EN
    expect_txn(1'b0, 32'h8000_0010, 1'b0, 32'h0, 8'h0, 32'hA0, 1'b0);
    expect_txn(1'b1, 32'h8000_2000, 1'b0, 32'h0, 8'h0, 32'hB0, 1'b0);
    expect_txn(1'b0, 32'h8000_0014, 1'b0, 32'h0, 8'h0, 32'hA1, 1'b0);
    expect_txn(1'b1, 32'h8000_2004, 1'b0, 32'h0, 8'h0, 32'hB1, 1'b0);
`else
    expect_txn(1'b1, 32'h8000_2000, 1'b0, 32'h0, 8'h0, 32'hB0, 1'b0);
    expect_txn(1'b1, 32'h8000_2004, 1'b0, 32'h0, 8'h0, 32'hB1, 1'b0);
    expect_txn(1'b0, 32'h8000_0010, 1'b0, 32'h0, 8'h0, 32'hA0, 1'b0);
    expect_txn(1'b0, 32'h8000_0014, 1'b0, 32'h0, 8'h0, 32'hA1, 1'b0);
`endif
    fork
      begin
        send0(32'h8000_0010, 1'b0, 32'h0, 8'h0, lat0);
        send0(32'h8000_0014, 1'b0, 32'h0, 8'h0, lat0);
      end
      begin
        send1(32'h8000_2000, 1'b0, 32'h0, 8'h0, lat1);
        send1(32'h8000_2004, 1'b0, 32'h0, 8'h0, lat1);
      end
    join
    drain();

    // ---- Backpressure on request then response ----
    s_req_ready = 1'b0;
    m0_resp_ready = 1'b0;
    expect_txn(1'b0, 32'h8000_0100, 1'b0, 32'h0, 8'h0, 32'hCAFE_F00D, 1'b1);
    fork
      send0(32'h8000_0100, 1'b0, 32'h0, 8'h0, lat0);
      begin
        @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          chk("bp s_req_valid", s_req_valid, 1'b1);
          chk("bp s_req_addr stable", s_req_addr, 32'h8000_0100);
          chk("bp m0_req_ready", m0_req_ready, 1'b0);
        end
        @(posedge clk); #1;
        s_req_ready = 1'b1;
        @(negedge clk);
        repeat (3) begin
          @(negedge clk);
          chk("bp m0_resp_valid", m0_resp_valid, 1'b1);
          chk("bp m0_resp_rdata", m0_resp_rdata, 32'hCAFE_F00D);
          chk("bp m0_resp_err", m0_resp_err, 1'b1);
          chk("bp s_resp_ready", s_resp_ready, 1'b0);
        end
        @(posedge clk); #1;
        m0_resp_ready = 1'b1;
      end
    join
    drain();
    @(negedge clk);
    chk("bp single delivery", m0_resp_valid, 1'b0);
    @(posedge clk); #1;

    // ---- Asynchronous reset while in RESP1 ----
    m1_resp_ready = 1'b0;
    expect_txn(1'b1, 32'h8000_3000, 1'b0, 32'h0, 8'h0, 32'h55, 1'b0);
    fork
      send1(32'h8000_3000, 1'b0, 32'h0, 8'h0, lat1);
      begin
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset m1_resp_valid", m1_resp_valid, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("async rst m1_resp_valid", m1_resp_valid, 1'b0);
        chk("async rst s_resp_ready", s_resp_ready, 1'b0);
        chk("async rst s_req_valid", s_req_valid, 1'b0);
      end
    join
    exp_r1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m1_resp_ready = 1'b1;
    @(negedge clk);
    chk("idle after reset release", {s_req_valid, m1_resp_valid, s_resp_ready}, 3'b000);
    chk("no leftover slave requests", exp_sreq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
